// File: rtl/microwave_pwr_ctrl_if.sv
// Front-panel and display/magnetron signals of the microwave controller.
// Inputs are levels or edge-acted pushbuttons; there is no flow control.
interface microwave_pwr_ctrl_if #(
  parameter int MIN_DIGITS = 1
);
  logic [9:0]              keypad;
  logic                    power_key;
  logic                    startn;
  logic                    stopn;
  logic                    clearn;
  logic                    door_closed;
  logic [6:0]              secs_ones_segs;
  logic [6:0]              secs_tens_segs;
  logic [7*MIN_DIGITS-1:0] min_segs;
  logic                    mag_on;
  logic                    cooking;
  logic                    done;
  logic [3:0]              power_level;

  modport master (
    output keypad, power_key, startn, stopn, clearn, door_closed,
    input  secs_ones_segs, secs_tens_segs, min_segs, mag_on, cooking, done, power_level
  );

  modport slave (
    input  keypad, power_key, startn, stopn, clearn, door_closed,
    output secs_ones_segs, secs_tens_segs, min_segs, mag_on, cooking, done, power_level
  );
endinterface

// File: rtl/microwave_pwr_ctrl.sv
// Microwave controller: BCD keypad entry, countdown, duty-cycled magnetron, 7-seg drive.
// Latency: panel events act on the sampling edge, outputs are Moore; no backpressure.
module microwave_pwr_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MIN_DIGITS    = 1
) (
  input logic                clk,
  input logic                rst,
  microwave_pwr_ctrl_if.slave panel
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {ENTRY, PWR, COOK, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    so_q, st_q, mo_q, mt_q;
  logic [3:0]    so_d, st_d, mo_d, mt_d;
  logic [3:0]    level_q, level_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    duty_q, duty_d;
  logic          done_q, done_d;

  logic [9:0]    keypad_q;
  logic          power_key_q, startn_q, stopn_q, clearn_q;

  logic          digit_evt, power_evt, start_evt, stop_evt, clear_evt;
  logic [3:0]    digit;
  logic [3:0]    dec_so, dec_st, dec_mo, dec_mt;
  logic          time_zero, dec_zero;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // A digit counts only when the keypad was idle last cycle and exactly one key is down now.
  assign digit_evt = (keypad_q == 10'd0) && $onehot(panel.keypad);
  assign power_evt = panel.power_key & ~power_key_q;
  assign start_evt = startn_q & ~panel.startn;
  assign stop_evt  = stopn_q & ~panel.stopn;
  assign clear_evt = clearn_q & ~panel.clearn;

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (panel.keypad[i]) digit = 4'(i);
    end
  end

  // BCD borrow chain; tens entered as 6-9 simply count down from where they are.
  always_comb begin
    dec_so = so_q - 4'd1;
    dec_st = st_q;
    dec_mo = mo_q;
    dec_mt = mt_q;
    if (so_q == 4'd0) begin
      dec_so = 4'd9;
      if (st_q == 4'd0) begin
        dec_st = 4'd5;
        if (mo_q == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = mt_q - 4'd1;
        end else begin
          dec_mo = mo_q - 4'd1;
        end
      end else begin
        dec_st = st_q - 4'd1;
      end
    end
  end

  assign time_zero = (so_q == 4'd0) && (st_q == 4'd0) && (mo_q == 4'd0) && (mt_q == 4'd0);
  assign dec_zero  = (dec_so == 4'd0) && (dec_st == 4'd0) && (dec_mo == 4'd0) && (dec_mt == 4'd0);

  always_comb begin
    state_d = state_q;
    so_d    = so_q;
    st_d    = st_q;
    mo_d    = mo_q;
    mt_d    = mt_q;
    level_d = level_q;
    presc_d = presc_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    if (clear_evt) begin
      state_d = ENTRY;
      so_d    = 4'd0;
      st_d    = 4'd0;
      mo_d    = 4'd0;
      mt_d    = 4'd0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (start_evt && panel.door_closed && !time_zero) begin
            state_d = COOK;
            presc_d = '0;
            duty_d  = 4'd0;
          end else if (digit_evt) begin
            mt_d = (MIN_DIGITS == 2) ? mo_q : 4'd0;
            mo_d = st_q;
            st_d = so_q;
            so_d = digit;
          end else if (power_evt) begin
            state_d = PWR;
          end
        end
        PWR: begin
          if (digit_evt) begin
            level_d = (digit == 4'd0) ? 4'd10 : digit;
            state_d = ENTRY;
          end
        end
        COOK: begin
          // An open door beats a coincident tick: the second is not consumed.
          if (stop_evt || !panel.door_closed) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            duty_d  = (duty_q == 4'd9) ? 4'd0 : duty_q + 4'd1;
            so_d    = dec_so;
            st_d    = dec_st;
            mo_d    = dec_mo;
            mt_d    = dec_mt;
            if (dec_zero) begin
              state_d = ENTRY;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (stop_evt) begin
            state_d = ENTRY;
          end else if (start_evt && panel.door_closed) begin
            state_d = COOK;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ENTRY;
      so_q        <= 4'd0;
      st_q        <= 4'd0;
      mo_q        <= 4'd0;
      mt_q        <= 4'd0;
      level_q     <= 4'd10;
      presc_q     <= '0;
      duty_q      <= 4'd0;
      done_q      <= 1'b0;
      keypad_q    <= 10'd0;
      power_key_q <= 1'b0;
      startn_q    <= 1'b1;
      stopn_q     <= 1'b1;
      clearn_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      so_q        <= so_d;
      st_q        <= st_d;
      mo_q        <= mo_d;
      mt_q        <= mt_d;
      level_q     <= level_d;
      presc_q     <= presc_d;
      duty_q      <= duty_d;
      done_q      <= done_d;
      keypad_q    <= panel.keypad;
      power_key_q <= panel.power_key;
      startn_q    <= panel.startn;
      stopn_q     <= panel.stopn;
      clearn_q    <= panel.clearn;
    end
  end

  assign panel.mag_on      = (state_q == COOK) && (duty_q < level_q);
  assign panel.cooking     = (state_q == COOK);
  assign panel.done        = done_q;
  assign panel.power_level = level_q;

  // In PWR the seconds digits show the level: tens lit only for 10.
  assign panel.secs_tens_segs = (state_q != PWR) ? seg7(st_q) :
                                (level_q == 4'd10) ? seg7(4'd1) : 7'b0000000;
  assign panel.secs_ones_segs = (state_q != PWR) ? seg7(so_q) :
                                (level_q == 4'd10) ? seg7(4'd0) : seg7(level_q);

  if (MIN_DIGITS == 2) begin : g_min2
    assign panel.min_segs = (state_q == PWR) ? 14'd0 : {seg7(mt_q), seg7(mo_q)};
  end else begin : g_min1
    assign panel.min_segs = (state_q == PWR) ? 7'd0 : seg7(mo_q);
  end
endmodule

// File: tb/tb_microwave_pwr_ctrl.sv
// Directed bench for microwave_pwr_ctrl with TICKS_PER_SEC=4, one minute digit.
module tb_microwave_pwr_ctrl;
  localparam int TPS = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  microwave_pwr_ctrl_if #(.MIN_DIGITS(1)) bus ();
  microwave_pwr_ctrl #(.TICKS_PER_SEC(TPS), .MIN_DIGITS(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .panel(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] disp(input int m, input int t, input int o);
    return {seg(m), seg(t), seg(o)};
  endfunction

  function automatic logic [20:0] shown();
    return {bus.min_segs, bus.secs_tens_segs, bus.secs_ones_segs};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    bus.keypad = 10'd1 << d;
    step();
    bus.keypad = 10'd0;
    step();
  endtask

  task automatic press_clear();
    bus.clearn = 1'b0;
    step();
    bus.clearn = 1'b1;
    step();
  endtask

  task automatic set_level(input int d);
    bus.power_key = 1'b1;
    step();
    bus.power_key = 1'b0;
    press(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    vectors++; if (shown() !== disp(0, 0, 0)) begin miscompares++; $display("FAIL reset_display: got %h want %h", shown(), disp(0, 0, 0)); end
    vectors++; if (bus.power_level !== 4'd10) begin miscompares++; $display("FAIL reset_level: got %0d want 10", bus.power_level); end
    vectors++; if (bus.mag_on !== 1'b0) begin miscompares++; $display("FAIL reset_mag_on: got %b want 0", bus.mag_on); end
    vectors++; if ({bus.cooking, bus.done} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {bus.cooking, bus.done}); end
  endtask

  task automatic test_entry_cook();
    press(1); press(0); press(5);
    vectors++; if (shown() !== disp(1, 0, 5)) begin miscompares++; $display("FAIL entry_105: got %h want %h", shown(), disp(1, 0, 5)); end
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    vectors++; if ({bus.mag_on, bus.cooking} !== 2'b11) begin miscompares++; $display("FAIL start_outputs: got %b want 11", {bus.mag_on, bus.cooking}); end
    step(); step(); step();
    vectors++; if (shown() !== disp(1, 0, 5)) begin miscompares++; $display("FAIL before_tick: got %h want %h", shown(), disp(1, 0, 5)); end
    step();
    vectors++; if (shown() !== disp(1, 0, 4)) begin miscompares++; $display("FAIL first_tick: got %h want %h", shown(), disp(1, 0, 4)); end
    bus.clearn = 1'b0;
    step();
    bus.clearn = 1'b1;
    vectors++; if ({bus.mag_on, bus.cooking} !== 2'b00) begin miscompares++; $display("FAIL clear_in_cook: got %b want 00", {bus.mag_on, bus.cooking}); end
    vectors++; if (shown() !== disp(0, 0, 0)) begin miscompares++; $display("FAIL clear_display: got %h want %h", shown(), disp(0, 0, 0)); end
    step();
  endtask

  task automatic test_done();
    int dones = 0;
    press(2);
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL done_on_final_tick: got %b want 1", bus.done); end
    vectors++; if (shown() !== disp(0, 0, 0)) begin miscompares++; $display("FAIL done_display: got %h want %h", shown(), disp(0, 0, 0)); end
    vectors++; if ({bus.mag_on, bus.cooking} !== 2'b00) begin miscompares++; $display("FAIL done_outputs: got %b want 00", {bus.mag_on, bus.cooking}); end
    step();
    if (bus.done === 1'b1) dones++;
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL done_pulse_count: got %0d want 1", dones); end
  endtask

  task automatic test_power();
    bus.power_key = 1'b1;
    step();
    bus.power_key = 1'b0;
    vectors++; if (shown() !== {7'h00, seg(1), seg(0)}) begin miscompares++; $display("FAIL pwr_display_10: got %h want %h", shown(), {7'h00, seg(1), seg(0)}); end
    press(3);
    vectors++; if (bus.power_level !== 4'd3) begin miscompares++; $display("FAIL level_3: got %0d want 3", bus.power_level); end
    press(1); press(2);
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    for (int i = 0; i < 48; i++) begin
      logic want;
      want = ((i / 4) % 10) < 3;
      vectors++; if (bus.mag_on !== want) begin miscompares++; $display("FAIL duty_cycle_%0d: got %b want %b", i, bus.mag_on, want); end
      if (i == 12) begin
        vectors++; if (shown() !== disp(0, 0, 9)) begin miscompares++; $display("FAIL borrow_0_09: got %h want %h", shown(), disp(0, 0, 9)); end
      end
      step();
    end
    vectors++; if ({bus.done, bus.cooking} !== 2'b10) begin miscompares++; $display("FAIL duty_run_end: got %b want 10", {bus.done, bus.cooking}); end
    set_level(0);
    vectors++; if (bus.power_level !== 4'd10) begin miscompares++; $display("FAIL level_zero_is_10: got %0d want 10", bus.power_level); end
  endtask

  task automatic test_pause();
    press(3); press(0);
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step(); step();
    bus.door_closed = 1'b0;
    step();
    vectors++; if ({bus.mag_on, bus.cooking} !== 2'b00) begin miscompares++; $display("FAIL door_open_outputs: got %b want 00", {bus.mag_on, bus.cooking}); end
    for (int i = 0; i < 10; i++) step();
    vectors++; if (shown() !== disp(0, 3, 0)) begin miscompares++; $display("FAIL pause_frozen: got %h want %h", shown(), disp(0, 3, 0)); end
    bus.door_closed = 1'b1;
    step();
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    vectors++; if (bus.cooking !== 1'b1) begin miscompares++; $display("FAIL resume_cooking: got %b want 1", bus.cooking); end
    step();
    vectors++; if (shown() !== disp(0, 3, 0)) begin miscompares++; $display("FAIL resume_before_tick: got %h want %h", shown(), disp(0, 3, 0)); end
    step();
    vectors++; if (shown() !== disp(0, 2, 9)) begin miscompares++; $display("FAIL resume_held_prescaler: got %h want %h", shown(), disp(0, 2, 9)); end
    step(); step(); step();
    bus.door_closed = 1'b0;
    step();
    vectors++; if (shown() !== disp(0, 2, 9)) begin miscompares++; $display("FAIL door_beats_tick: got %h want %h", shown(), disp(0, 2, 9)); end
    bus.door_closed = 1'b1;
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
    step();
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    // From ENTRY with 0:29 left a start re-enters COOK, proving stop left PAUSE with the time kept.
    vectors++; if ({bus.cooking, shown()} !== {1'b1, disp(0, 2, 9)}) begin miscompares++; $display("FAIL stop_keeps_time: got %h want %h", {bus.cooking, shown()}, {1'b1, disp(0, 2, 9)}); end
    press_clear();
  endtask

  task automatic test_borrow();
    press(1); press(9); press(0);
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step(); step(); step(); step();
    vectors++; if (shown() !== disp(1, 8, 9)) begin miscompares++; $display("FAIL tens_above_5: got %h want %h", shown(), disp(1, 8, 9)); end
    press_clear();
    press(1); press(0); press(0);
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step(); step(); step(); step();
    vectors++; if (shown() !== disp(0, 5, 9)) begin miscompares++; $display("FAIL minute_borrow: got %h want %h", shown(), disp(0, 5, 9)); end
    press_clear();
  endtask

  task automatic test_ignored();
    bus.keypad = (10'd1 << 4) | (10'd1 << 7);
    step();
    bus.keypad = 10'd0;
    step();
    vectors++; if (shown() !== disp(0, 0, 0)) begin miscompares++; $display("FAIL multi_key: got %h want %h", shown(), disp(0, 0, 0)); end
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    vectors++; if ({bus.mag_on, bus.cooking} !== 2'b00) begin miscompares++; $display("FAIL start_at_zero: got %b want 00", {bus.mag_on, bus.cooking}); end
    step();
    press(5);
    bus.door_closed = 1'b0;
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    vectors++; if (bus.cooking !== 1'b0) begin miscompares++; $display("FAIL start_door_open: got %b want 0", bus.cooking); end
    bus.door_closed = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    press_clear();
    bus.keypad = 10'd1 << 1;
    step(); step(); step();
    bus.keypad = 10'd1 << 2;
    step();
    bus.keypad = 10'd0;
    step();
    vectors++; if (shown() !== disp(0, 0, 1)) begin miscompares++; $display("FAIL held_and_rolled_keys: got %h want %h", shown(), disp(0, 0, 1)); end
    press(4);
    vectors++; if (shown() !== disp(0, 1, 4)) begin miscompares++; $display("FAIL after_release: got %h want %h", shown(), disp(0, 1, 4)); end
  endtask

  task automatic test_reset_mid_cook();
    set_level(5);
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step();
    vectors++; if (bus.mag_on !== 1'b1) begin miscompares++; $display("FAIL cook_before_reset: got %b want 1", bus.mag_on); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if ({bus.mag_on, bus.cooking} !== 2'b00) begin miscompares++; $display("FAIL reset_mid_cook: got %b want 00", {bus.mag_on, bus.cooking}); end
    vectors++; if (bus.power_level !== 4'd10) begin miscompares++; $display("FAIL reset_level_restored: got %0d want 10", bus.power_level); end
    vectors++; if (shown() !== disp(0, 0, 0)) begin miscompares++; $display("FAIL reset_time_cleared: got %h want %h", shown(), disp(0, 0, 0)); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.keypad      = 10'd0;
    bus.power_key   = 1'b0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b1;
    test_reset();
    test_entry_cook();
    test_done();
    test_power();
    test_pause();
    test_borrow();
    test_ignored();
    test_back_to_back();
    test_reset_mid_cook();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
